// File: rtl/pixel_stream_writer.sv
// pixel_stream_writer: raster pixel stream to circular line-store write port, with row/window/frame status.
// Optional STREAM_WRITER_ERR_EN adds a sticky O_SHORT_FRAME_ERR for truncated lines or frames.
module pixel_stream_writer #(
    parameter int P_COLUMNS     = 640,
    parameter int P_ROWS        = 3,
    parameter int P_PIXEL_DEPTH = 24,
    parameter int P_FRAME_LINES = 480
) (
    input  logic                         I_CLK,
    input  logic                         I_RESET,
    input  logic                         I_ENABLE,
    input  logic                         I_FRAME_START,
    input  logic                         I_PIXEL_VALID,
    input  logic [P_PIXEL_DEPTH-1:0]     I_PIXEL,
    input  logic                         I_HOLD,
    output logic                         O_PIXEL_READY,
    output logic [$clog2(P_COLUMNS)-1:0] O_BUF_PIXEL_COL,
    output logic [$clog2(P_ROWS)-1:0]    O_BUF_PIXEL_ROW,
    output logic [P_PIXEL_DEPTH-1:0]     O_BUF_PIXEL,
    output logic                         O_BUF_WRITE_ENABLE,
    output logic                         O_BUF_READ_ENABLE,
    output logic                         O_ROW_DONE,
    output logic                         O_WINDOW_VALID,
`ifdef STREAM_WRITER_ERR_EN
    output logic                         O_SHORT_FRAME_ERR,
`endif
    output logic                         O_FRAME_DONE
);
    localparam int CW = $clog2(P_COLUMNS);
    localparam int RW = $clog2(P_ROWS);
    localparam int FW = $clog2(P_ROWS + 1);
    localparam int LW = $clog2(P_FRAME_LINES + 1);

    typedef enum logic [1:0] {IDLE, FILL, ROW_END, DONE} state_t;

    state_t                   state_q, state_d;
    logic [CW-1:0]            col_q, col_d, buf_col_q, buf_col_d;
    logic [RW-1:0]            row_q, row_d, buf_row_q, buf_row_d;
    logic [FW-1:0]            rows_filled_q, rows_filled_d;
    logic [LW-1:0]            line_cnt_q, line_cnt_d;
    logic [P_PIXEL_DEPTH-1:0] buf_pixel_q, buf_pixel_d;
    logic                     we_q, we_d, row_done_q, row_done_d;
    logic                     window_q, window_d, frame_done_q, frame_done_d;
    logic                     err_q, err_d;
    logic                     accept, last_col, frame_end;

    assign O_PIXEL_READY = (state_q == FILL) & I_ENABLE & ~I_HOLD & ~I_FRAME_START;
    assign accept        = O_PIXEL_READY & I_PIXEL_VALID;
    assign last_col      = col_q == CW'(P_COLUMNS - 1);
    assign frame_end     = line_cnt_q == LW'(P_FRAME_LINES);

    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        row_d         = row_q;
        rows_filled_d = rows_filled_q;
        line_cnt_d    = line_cnt_q;
        buf_col_d     = buf_col_q;
        buf_row_d     = buf_row_q;
        buf_pixel_d   = buf_pixel_q;
        err_d         = err_q;
        we_d          = 1'b0;
        row_done_d    = 1'b0;
        frame_done_d  = 1'b0;
        if (I_ENABLE && I_FRAME_START) begin
            err_d         = err_q | (((state_q == FILL) || (state_q == ROW_END)) &&
                                     ((col_q != '0) || (line_cnt_q < LW'(P_FRAME_LINES))));
            state_d       = FILL;
            col_d         = '0;
            row_d         = '0;
            rows_filled_d = '0;
            line_cnt_d    = '0;
        end else if (I_ENABLE) begin
            case (state_q)
                IDLE: state_d = IDLE;
                FILL: if (accept) begin
                    buf_col_d   = col_q;
                    buf_row_d   = row_q;
                    buf_pixel_d = I_PIXEL;
                    we_d        = 1'b1;
                    col_d       = last_col ? '0 : col_q + CW'(1);
                    if (last_col) begin
                        row_d         = (row_q == RW'(P_ROWS - 1)) ? '0 : row_q + RW'(1);
                        line_cnt_d    = line_cnt_q + LW'(1);
                        rows_filled_d = (rows_filled_q == FW'(P_ROWS)) ? rows_filled_q : rows_filled_q + FW'(1);
                        row_done_d    = 1'b1;
                        state_d       = ROW_END;
                    end
                end
                ROW_END: begin
                    state_d      = frame_end ? DONE : FILL;
                    frame_done_d = frame_end;
                end
                default: state_d = IDLE;
            endcase
        end
        window_d = rows_filled_d == FW'(P_ROWS);
    end

    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            state_q       <= IDLE;
            col_q         <= '0;
            row_q         <= '0;
            rows_filled_q <= '0;
            line_cnt_q    <= '0;
            buf_col_q     <= '0;
            buf_row_q     <= '0;
            buf_pixel_q   <= '0;
            we_q          <= 1'b0;
            row_done_q    <= 1'b0;
            window_q      <= 1'b0;
            frame_done_q  <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            row_q         <= row_d;
            rows_filled_q <= rows_filled_d;
            line_cnt_q    <= line_cnt_d;
            buf_col_q     <= buf_col_d;
            buf_row_q     <= buf_row_d;
            buf_pixel_q   <= buf_pixel_d;
            we_q          <= we_d;
            row_done_q    <= row_done_d;
            window_q      <= window_d;
            frame_done_q  <= frame_done_d;
            err_q         <= err_d;
        end
    end

    assign O_BUF_PIXEL_COL    = buf_col_q;
    assign O_BUF_PIXEL_ROW    = buf_row_q;
    assign O_BUF_PIXEL        = buf_pixel_q;
    assign O_BUF_WRITE_ENABLE = we_q;
    assign O_BUF_READ_ENABLE  = 1'b0;
    assign O_ROW_DONE         = row_done_q;
    assign O_WINDOW_VALID     = window_q;
    assign O_FRAME_DONE       = frame_done_q;
`ifdef STREAM_WRITER_ERR_EN
    assign O_SHORT_FRAME_ERR  = err_q;
`else
    logic unused_err;
    assign unused_err = err_q;
`endif
endmodule

// File: tb/tb_pixel_stream_writer.sv
// tb_pixel_stream_writer: directed scenarios for pixel_stream_writer with a 4x3 line store, 4-line frames.
module tb_pixel_stream_writer;
    logic        clk = 1'b0;
    logic        rst, en, fs, valid, hold;
    logic [23:0] pixel;
    logic        ready, we, re, row_done, window, frame_done, err;
    logic [1:0]  col, row;
    logic [23:0] bufpix;
    int          vectors = 0;
    int          miscompares = 0;

    pixel_stream_writer #(.P_COLUMNS(4), .P_ROWS(3), .P_PIXEL_DEPTH(24), .P_FRAME_LINES(4)) dut (
        .I_CLK(clk), .I_RESET(rst), .I_ENABLE(en), .I_FRAME_START(fs),
        .I_PIXEL_VALID(valid), .I_PIXEL(pixel), .I_HOLD(hold),
        .O_PIXEL_READY(ready), .O_BUF_PIXEL_COL(col), .O_BUF_PIXEL_ROW(row),
        .O_BUF_PIXEL(bufpix), .O_BUF_WRITE_ENABLE(we), .O_BUF_READ_ENABLE(re),
        .O_ROW_DONE(row_done), .O_WINDOW_VALID(window),
`ifdef STREAM_WRITER_ERR_EN
        .O_SHORT_FRAME_ERR(err),
`endif
        .O_FRAME_DONE(frame_done)
    );
`ifndef STREAM_WRITER_ERR_EN
    assign err = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frame_start();
        fs = 1'b1;
        valid = 1'b0;
        step();
        fs = 1'b0;
    endtask

    task automatic send_pixel(input logic [23:0] p);
        int n = 0;
        pixel = p;
        valid = 1'b1;
        #1;
        while (!ready && n < 10) begin
            step();
            n++;
        end
        vectors++;
        if (ready !== 1'b1) begin
            miscompares++;
            $display("FAIL send_timeout: ready=%b expected 1 for pixel %h", ready, p);
        end
        step();
        valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; fs = 1'b0; valid = 1'b0; hold = 1'b0; pixel = '0;
        step(); step();
        rst = 1'b0;
        vectors++;
        if ({ready, we, re, row_done, window, frame_done, col, row, bufpix} !== 33'd0) begin
            miscompares++;
            $display("FAIL reset_state: got %h expected 0", {ready, we, re, row_done, window, frame_done, col, row, bufpix});
        end
        frame_start();
        pixel = 24'h123456; valid = 1'b1;
        step();
        vectors++;
        if ({we, bufpix} !== {1'b1, 24'h123456}) begin
            miscompares++;
            $display("FAIL reset_pre_write: got %h expected %h", {we, bufpix}, {1'b1, 24'h123456});
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({ready, we, re, row_done, window, frame_done, col, row, bufpix} !== 33'd0) begin
            miscompares++;
            $display("FAIL reset_async: got %h expected 0", {ready, we, re, row_done, window, frame_done, col, row, bufpix});
        end
        #1 rst = 1'b0;
        step();
        vectors++;
        if ({ready, we} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_no_ready: ready,we=%b expected 00", {ready, we});
        end
        valid = 1'b0;
    endtask

    task automatic test_frame();
        int rd = 0;
        logic [1:0] exp_col, exp_row;
        logic exp_done, exp_win;
        frame_start();
        for (int i = 0; i < 16; i++) begin
            if (i > 0 && i % 4 == 0) begin
                valid = 1'b1;
                pixel = 24'(i + 1);
                #1;
                vectors++;
                if (ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL row_end_ready: ready=%b expected 0 before pixel %0d", ready, i);
                end
            end
            send_pixel(24'(i + 1));
            exp_col  = 2'(i % 4);
            exp_row  = 2'((i / 4) % 3);
            exp_done = (i % 4 == 3);
            exp_win  = ((i + 1) / 4 >= 3);
            vectors++;
            if ({we, col, row, bufpix, row_done, window} !== {1'b1, exp_col, exp_row, 24'(i + 1), exp_done, exp_win}) begin
                miscompares++;
                $display("FAIL frame_write[%0d]: we=%b col=%0d row=%0d pix=%h rd=%b win=%b expected we=1 col=%0d row=%0d pix=%h rd=%b win=%b",
                         i, we, col, row, bufpix, row_done, window, exp_col, exp_row, 24'(i + 1), exp_done, exp_win);
            end
            if (row_done) rd++;
        end
        vectors++;
        if (rd !== 4) begin
            miscompares++;
            $display("FAIL row_done_count: got %0d expected 4", rd);
        end
        step();
        vectors++;
        if ({frame_done, window, we} !== 3'b110) begin
            miscompares++;
            $display("FAIL frame_done_pulse: fd,win,we=%b expected 110", {frame_done, window, we});
        end
        step();
        valid = 1'b1;
        #1;
        vectors++;
        if ({frame_done, ready} !== 2'b00) begin
            miscompares++;
            $display("FAIL frame_idle: fd,ready=%b expected 00", {frame_done, ready});
        end
        valid = 1'b0;
    endtask

    task automatic test_hold();
        frame_start();
        send_pixel(24'hA0);
        send_pixel(24'hA1);
        hold = 1'b1; valid = 1'b1; pixel = 24'hA2;
        for (int k = 0; k < 5; k++) begin
            step();
            vectors++;
            if ({ready, we, col, bufpix} !== {1'b0, 1'b0, 2'd1, 24'hA1}) begin
                miscompares++;
                $display("FAIL hold[%0d]: ready=%b we=%b col=%0d pix=%h expected 0 0 1 a1", k, ready, we, col, bufpix);
            end
        end
        hold = 1'b0;
        step();
        vectors++;
        if ({we, col, row, bufpix} !== {1'b1, 2'd2, 2'd0, 24'hA2}) begin
            miscompares++;
            $display("FAIL hold_resume: we=%b col=%0d row=%0d pix=%h expected 1 2 0 a2", we, col, row, bufpix);
        end
        valid = 1'b0;
    endtask

    task automatic test_restart();
        frame_start();
        for (int i = 0; i < 12; i++) send_pixel(24'h100 + 24'(i));
        send_pixel(24'hB0);
        send_pixel(24'hB1);
        vectors++;
        if ({window, col} !== {1'b1, 2'd1}) begin
            miscompares++;
            $display("FAIL restart_pre: win=%b col=%0d expected 1 1", window, col);
        end
        fs = 1'b1; valid = 1'b1; pixel = 24'hBB;
        #1;
        vectors++;
        if (ready !== 1'b0) begin
            miscompares++;
            $display("FAIL restart_ready: ready=%b expected 0", ready);
        end
        step();
        fs = 1'b0;
        vectors++;
        if ({we, window} !== 2'b00) begin
            miscompares++;
            $display("FAIL restart_clear: we,win=%b expected 00", {we, window});
        end
        send_pixel(24'hCC);
        vectors++;
        if ({we, col, row, bufpix} !== {1'b1, 2'd0, 2'd0, 24'hCC}) begin
            miscompares++;
            $display("FAIL restart_write: we=%b col=%0d row=%0d pix=%h expected 1 0 0 cc", we, col, row, bufpix);
        end
`ifdef STREAM_WRITER_ERR_EN
        vectors++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL restart_err: err=%b expected 1", err);
        end
`endif
    endtask

    task automatic test_enable();
        frame_start();
        send_pixel(24'hE0);
        send_pixel(24'hE1);
        en = 1'b0; valid = 1'b1; pixel = 24'hE2;
        for (int k = 0; k < 3; k++) begin
            step();
            vectors++;
            if ({ready, we, col, bufpix} !== {1'b0, 1'b0, 2'd1, 24'hE1}) begin
                miscompares++;
                $display("FAIL enable_low[%0d]: ready=%b we=%b col=%0d pix=%h expected 0 0 1 e1", k, ready, we, col, bufpix);
            end
        end
        en = 1'b1;
        step();
        vectors++;
        if ({we, col, row, bufpix} !== {1'b1, 2'd2, 2'd0, 24'hE2}) begin
            miscompares++;
            $display("FAIL enable_resume: we=%b col=%0d row=%0d pix=%h expected 1 2 0 e2", we, col, row, bufpix);
        end
        valid = 1'b0;
    endtask

    task automatic test_err();
`ifdef STREAM_WRITER_ERR_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        frame_start();
        for (int i = 0; i < 5; i++) send_pixel(24'h200 + 24'(i));
        vectors++;
        if ({err, col} !== {1'b0, 2'd0}) begin
            miscompares++;
            $display("FAIL err_clear: err=%b col=%0d expected 0 0", err, col);
        end
        frame_start();
        vectors++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_set: err=%b expected 1", err);
        end
        for (int i = 0; i < 16; i++) send_pixel(24'h300 + 24'(i));
        step();
        vectors++;
        if ({frame_done, err} !== 2'b11) begin
            miscompares++;
            $display("FAIL err_sticky: fd,err=%b expected 11", {frame_done, err});
        end
        step();
        frame_start();
        vectors++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_sticky_restart: err=%b expected 1", err);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_frame();
        test_hold();
        test_restart();
        test_enable();
        test_err();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/pixel_stream_writer.md
Name: pixel_stream_writer

Overview:
- Upstream write controller for the line frame buffer in the colorspace path.
- Accepts a raster-order 24-bit pixel stream with a valid/ready handshake.
- Generates row/column addresses and write strobes for the frame buffer, treating its rows as a circular line store.
- Reports row completion, window readiness (enough rows buffered for a 3x3 kernel) and frame completion to the downstream edge-detection stage.

Parameters:
- P_COLUMNS, 640, pixels per line; frame buffer column count.
- P_ROWS, 3, rows held in the frame buffer; row index wraps modulo this value.
- P_PIXEL_DEPTH, 24, pixel width in bits.
- P_FRAME_LINES, 480, lines per frame.

Ports:
- I_CLK  in  1  clock.
- I_RESET  in  1  asynchronous, active-high reset.
- I_ENABLE  in  1  global enable; low freezes all state.
- I_FRAME_START  in  1  single-cycle start-of-frame pulse.
- I_PIXEL_VALID  in  1  upstream pixel valid.
- I_PIXEL  in  P_PIXEL_DEPTH  upstream pixel data.
- I_HOLD  in  1  downstream backpressure; blocks acceptance.
- O_PIXEL_READY  out  1  pixel accepted when VALID&READY.
- O_BUF_PIXEL_COL  out  $clog2(P_COLUMNS)  write column.
- O_BUF_PIXEL_ROW  out  $clog2(P_ROWS)  write row.
- O_BUF_PIXEL  out  P_PIXEL_DEPTH  write data.
- O_BUF_WRITE_ENABLE  out  1  write strobe to the frame buffer.
- O_BUF_READ_ENABLE  out  1  constant 0; this block never reads.
- O_ROW_DONE  out  1  one-cycle pulse after the last pixel of a line is written.
- O_WINDOW_VALID  out  1  high once P_ROWS lines of the current frame are buffered.
- O_FRAME_DONE  out  1  one-cycle pulse after the last line of the frame.

Behaviour:
- Reset (async): state IDLE; all counters 0; every output 0.
- I_ENABLE low: all registers hold; O_BUF_WRITE_ENABLE, O_ROW_DONE and O_FRAME_DONE are forced 0 on the next edge; O_PIXEL_READY is 0.
- O_PIXEL_READY is combinational:
  - = (state==FILL) & I_ENABLE & ~I_HOLD & ~I_FRAME_START.
- States:
  - IDLE: waits for I_FRAME_START, then goes to FILL.
  - FILL: accepts pixels.
  - ROW_END: one cycle with ready low; then FILL, or DONE if line_cnt==P_FRAME_LINES.
  - DONE: pulses O_FRAME_DONE for one cycle, then IDLE.
- I_FRAME_START in any state (while enabled):
  - col, row, rows_filled and line_cnt all go to 0; O_WINDOW_VALID goes to 0; next state FILL.
  - A pixel presented in the same cycle is NOT accepted.
- Accept (FILL, VALID&READY): on the next edge, O_BUF_PIXEL_COL/ROW receive the current col/row, O_BUF_PIXEL receives I_PIXEL, and O_BUF_WRITE_ENABLE=1 for exactly one cycle. Latency: 1 cycle.
- Column: col increments per accept.
- End of line (accept at col==P_COLUMNS-1):
  - col wraps to 0.
  - row = (row==P_ROWS-1) ? 0 : row+1.
  - line_cnt++.
  - rows_filled saturates at P_ROWS.
  - O_ROW_DONE pulses on the same edge as the final write strobe.
  - State goes to ROW_END.
- O_WINDOW_VALID = (rows_filled==P_ROWS); registered; stays high for the rest of the frame.
- No accept cycle leaves the address/data outputs unchanged; only the strobe drops.
- I_HOLD high mid-line: no acceptance and no counter change; the line resumes exactly where it stopped.
- Pixels offered in IDLE, ROW_END or DONE are not accepted (ready=0).

Optional Feature:
- Macro: STREAM_WRITER_ERR_EN.
- Defined:
  - Adds output O_SHORT_FRAME_ERR (1 bit), sticky.
  - Set when I_FRAME_START arrives while state is FILL or ROW_END and either col!=0 or line_cnt<P_FRAME_LINES (truncated line or frame).
  - Cleared only by I_RESET.
- Undefined: the port and its logic are absent; a truncated frame is silently restarted.

Test Plan (P_COLUMNS=4, P_ROWS=3, P_FRAME_LINES=4 unless noted):
- Reset mid-FILL with write strobe high -> all outputs 0 immediately (asynchronous); ready 0 until the next I_FRAME_START.
- FRAME_START, then 16 back-to-back pixels 0x000001..0x000010:
  - ROW/COL sequence (0,0)..(0,3),(1,0)..(2,3),(0,0)..(0,3); the 4th line wraps to row 0.
  - O_ROW_DONE pulses 4 times.
  - O_WINDOW_VALID rises on the 3rd O_ROW_DONE edge.
  - O_FRAME_DONE pulses once, then IDLE.
- I_HOLD high for 5 cycles after the 2nd pixel -> ready 0, no strobes; on release the next write lands at col 2 with the correct data.
- I_FRAME_START coincident with a valid pixel at col 2 -> pixel not accepted; next accepted pixel is written at (0,0); O_WINDOW_VALID cleared.
- I_ENABLE low for 3 cycles mid-line -> no strobes, counters frozen, stream resumes at the same column.
- STREAM_WRITER_ERR_EN defined: FRAME_START at col 1 of line 2 -> O_SHORT_FRAME_ERR=1, and it stays 1 through a subsequent complete frame.
